// File: rtl/pwm_ramp_ctrl_if.sv
// pwm_ramp_ctrl_if: valid/ready command channel carrying a duty target and slew rate.
interface pwm_ramp_ctrl_if #(
   parameter int N      = 8,
   parameter int RATE_W = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [N-1:0]      cmd_target;
   logic [RATE_W-1:0] cmd_rate;
   modport master (output cmd_valid, cmd_target, cmd_rate, input cmd_ready);
   modport slave  (input cmd_valid, cmd_target, cmd_rate, output cmd_ready);
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: prescaled step strobe, PWM phase tracker and period-aligned duty slew.
module pwm_ramp_ctrl #(
   parameter int N          = 8,
   parameter int PRESCALE_W = 16,
   parameter int RATE_W     = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   input  logic [PRESCALE_W-1:0] prescale,
   pwm_ramp_ctrl_if.slave        cmd,
   output logic                  step,
   output logic [N-1:0]          duty,
   output logic                  period_start,
   output logic                  busy
);
   typedef enum logic {IDLE, RAMP} state_t;
   state_t                state_q, state_d;
   logic [PRESCALE_W-1:0] pre_q, pre_d;
   logic [N-1:0]          phase_q, phase_d, duty_q, duty_d, target_q, target_d;
   logic [RATE_W-1:0]     rate_q, rate_d, rcnt_q, rcnt_d;

   // >= compare so a lowered prescale fires at once instead of wrapping the counter
   assign step         = ena & ~rst & (pre_q >= prescale);
   assign pre_d        = !ena ? pre_q : step ? '0 : pre_q + 1'b1;
   assign phase_d      = step ? phase_q + 1'b1 : phase_q;
   assign period_start = step & (&phase_q);
   assign duty         = duty_q;
   assign busy         = (state_q == RAMP);
   assign cmd.cmd_ready = (state_q == IDLE);

   always_comb begin
      state_d  = state_q;
      duty_d   = duty_q;
      target_d = target_q;
      rate_d   = rate_q;
      rcnt_d   = rcnt_q;
      if (state_q == IDLE) begin
         if (cmd.cmd_valid) begin
            target_d = cmd.cmd_target;
            rate_d   = cmd.cmd_rate;
            rcnt_d   = '0;
            state_d  = (cmd.cmd_target == duty_q) ? IDLE : RAMP;
         end
      end else if (period_start) begin
         if (rcnt_q == rate_q) begin
            duty_d  = (target_q > duty_q) ? duty_q + 1'b1 : duty_q - 1'b1;
            rcnt_d  = '0;
            state_d = (duty_d == target_q) ? IDLE : RAMP;
         end else begin
            rcnt_d = rcnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         pre_q    <= '0;
         phase_q  <= '0;
         duty_q   <= '0;
         target_q <= '0;
         rate_q   <= '0;
         rcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         pre_q    <= pre_d;
         phase_q  <= phase_d;
         duty_q   <= duty_d;
         target_q <= target_d;
         rate_q   <= rate_d;
         rcnt_q   <= rcnt_d;
      end
   end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: directed stimulus; a monitor pops expected duty moves and their period spacing.
module tb_pwm_ramp_ctrl;
   typedef struct { int duty; int periods; } exp_t;

   logic        clk, rst, ena;
   logic [15:0] prescale;
   logic        step, period_start, busy;
   logic [3:0]  duty;
   int          passed = 0, total = 0;
   exp_t        q[$];

   pwm_ramp_ctrl_if #(.N(4), .RATE_W(8)) cif ();

   pwm_ramp_ctrl #(.N(4), .PRESCALE_W(16), .RATE_W(8)) dut (
      .clk(clk), .rst(rst), .ena(ena), .prescale(prescale), .cmd(cif),
      .step(step), .duty(duty), .period_start(period_start), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      else passed++;
   endtask

   task automatic push(input int d, input int p);
      exp_t e;
      e.duty = d;
      e.periods = p;
      q.push_back(e);
   endtask

   task automatic send(input int t, input int r, output int acc_duty);
      int n;
      acc_duty = -1;
      cif.cmd_valid  = 1'b1;
      cif.cmd_target = t[3:0];
      cif.cmd_rate   = r[7:0];
      for (n = 0; n < 2000; n++) begin
         #1;
         if (cif.cmd_ready) begin
            acc_duty = int'(duty);
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      cif.cmd_valid = 1'b0;
      check("cmd_accepted", n < 2000, 1);
   endtask

   task automatic wait_duty(input int v, output int rdy_hi, output logic busy_prev);
      rdy_hi = 0;
      busy_prev = busy;
      for (int n = 0; n < 2000; n++) begin
         busy_prev = busy;
         @(negedge clk);
         #1;
         if (int'(duty) == v) break;
         if (cif.cmd_ready) rdy_hi++;
      end
      check("wait_duty", duty, v);
   endtask

   logic [3:0] m_prev = '0;
   logic       m_ps = 1'b0, m_acc = 1'b0;
   int         m_per = 0;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (rst) m_per = 0;
         else if (duty !== m_prev) begin
            check("change_on_boundary", m_ps, 1);
            if (q.size() == 0) begin
               total++;
               $display("FAIL unexpected_duty_change: got %0d expected %0d", duty, m_prev);
            end else begin
               e = q.pop_front();
               check("duty_value", duty, e.duty);
               check("duty_periods", m_per + 1, e.periods);
            end
            m_per = 0;
         end else if (m_acc) m_per = 0;
         else if (m_ps) m_per++;
         m_prev = duty;
         m_ps   = period_start;
         m_acc  = cif.cmd_valid & cif.cmd_ready;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   nstep, nps, first, acc, rdy;
      logic bprev;
      logic [4:0] pat;
      rst = 1'b1; ena = 1'b1; prescale = 16'd0;
      cif.cmd_valid = 1'b0; cif.cmd_target = '0; cif.cmd_rate = '0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_step", step, 0);
      check("rst_duty", duty, 0);
      check("rst_period_start", period_start, 0);
      check("rst_busy", busy, 0);
      check("rst_cmd_ready", cif.cmd_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      nstep = 0; nps = 0; first = -1;
      for (int i = 0; i < 32; i++) begin
         #1;
         nstep += int'(step);
         if (period_start) begin nps++; if (first < 0) first = i; end
         @(negedge clk);
      end
      check("step_every_cycle", nstep, 32);
      check("period_start_count", nps, 2);
      check("period_start_first", first, 15);

      prescale = 16'd3;
      nstep = 0; first = -1;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (step) begin nstep++; if (first < 0) first = i; end
         @(negedge clk);
      end
      check("prescale3_steps", nstep, 3);
      check("prescale3_first", first, 3);
      repeat (2) @(negedge clk);
      prescale = 16'd1;
      for (int i = 0; i < 5; i++) begin
         #1;
         pat[i] = step;
         @(negedge clk);
      end
      check("prescale_lowered", pat, 5'b10101);

      prescale = 16'd0;
      for (int d = 1; d <= 5; d++) push(d, 1);
      send(5, 0, acc);
      wait_duty(5, rdy, bprev);
      check("up_ready_low", rdy, 0);
      check("up_busy_before", bprev, 1);
      check("up_busy_after", busy, 0);
      check("up_ready_after", cif.cmd_ready, 1);

      @(negedge clk);
      for (int d = 4; d >= 2; d--) push(d, 3);
      send(2, 2, acc);
      send(2, 0, acc);
      check("held_cmd_after_ramp", acc, 2);
      repeat (20) @(negedge clk);
      #1;
      check("equal_target_busy", busy, 0);
      check("equal_target_duty", duty, 2);

      @(negedge clk);
      for (int d = 3; d <= 8; d++) push(d, 2);
      send(8, 1, acc);
      wait_duty(4, rdy, bprev);
      @(negedge clk);
      ena = 1'b0;
      nstep = 0; nps = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         nstep += int'(step);
         nps += int'(period_start);
         @(negedge clk);
      end
      check("pause_step", nstep, 0);
      check("pause_period_start", nps, 0);
      check("pause_duty", duty, 4);
      check("pause_busy", busy, 1);
      ena = 1'b1;
      wait_duty(8, rdy, bprev);

      @(negedge clk);
      for (int d = 9; d <= 15; d++) push(d, 1);
      send(15, 0, acc);
      wait_duty(15, rdy, bprev);
      repeat (40) @(negedge clk);
      #1;
      check("top_duty_held", duty, 15);
      check("top_busy", busy, 0);

      @(negedge clk);
      push(14, 1); push(13, 1);
      send(0, 0, acc);
      wait_duty(13, rdy, bprev);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_duty", duty, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_ready", cif.cmd_ready, 1);
      check("async_rst_step", step, 0);
      check("async_rst_period_start", period_start, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      #1;
      check("post_rst_duty", duty, 0);
      check("post_rst_busy", busy, 0);
      check("queue_drained", q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
